// File: rtl/ray_scene_scheduler_pkg.sv
// Shared types and constants for the ray scene scheduler.
// Distances are signed Q4.28 fixed point.
package ray_scene_scheduler_pkg;

   localparam int RAY_W = 192;
   localparam int TRI_W = 288;

   typedef logic signed [31:0] fixed_t;

   localparam fixed_t FMAX_T  = 32'sh7fffffff;
   localparam fixed_t FP0P001 = 32'sh00041893;  // 0.001 in Q4.28, truncated

   typedef struct packed {
      logic   hit;
      fixed_t t;
   } hit_rec_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_DONE
   } state_t;

   // A returned hit only counts if it lies strictly in front of the epsilon
   // and strictly closer than the current best, so ties keep the earlier index.
   function automatic logic qualifies(input logic hit, input fixed_t t, input fixed_t best_t);
      return hit && (t > FP0P001) && (t < best_t);
   endfunction

endpackage

// File: rtl/ray_scene_scheduler_closest_hit_tracker.sv
// Closest-hit register for one ray: clears on ray accept and keeps the
// nearest qualifying return together with its triangle index.
module closest_hit_tracker
   import ray_scene_scheduler_pkg::*;
#(
   parameter int IDX_W = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             update,
   input  logic             hit,
   input  fixed_t           hit_t,
   input  logic [IDX_W-1:0] idx,
   output logic             qual,
   output hit_rec_t         best,
   output logic [IDX_W-1:0] best_idx
);

   assign qual = qualifies(hit, hit_t, best.t);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         best     <= '{hit: 1'b0, t: FMAX_T};
         best_idx <= '0;
      end else if (update && qual) begin
         best     <= '{hit: 1'b1, t: hit_t};
         best_idx <= idx;
      end
   end

endmodule

// File: rtl/ray_scene_scheduler.sv
// Per-ray scheduler: streams {ray, triangle} pairs into the intersection unit
// and reduces the returns to the closest hit. RAYSCHED_ANYHIT_EN adds any-hit mode.
module ray_scene_scheduler
   import ray_scene_scheduler_pkg::*;
#(
   parameter int IDX_W     = 10,
   parameter int ID_W      = 8,
   parameter int ISECT_LAT = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ray_valid,
   output logic             ray_ready,
   input  logic [RAY_W-1:0] ray_in,
   input  logic [ID_W-1:0]  ray_id,
   input  logic [IDX_W-1:0] num_tris,
`ifdef RAYSCHED_ANYHIT_EN
   input  logic             ray_anyhit,
`endif
   output logic             tri_rd,
   output logic [IDX_W-1:0] tri_addr,
   input  logic [TRI_W-1:0] tri_data,
   output logic             isect_valid,
   output logic [RAY_W-1:0] isect_ray,
   output logic [TRI_W-1:0] isect_tri,
   input  logic             hit_valid,
   input  logic             hit,
   input  logic [31:0]      hit_t,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [31:0]      res_t,
   output logic [IDX_W-1:0] res_idx,
   output logic [ID_W-1:0]  res_id,
   output logic             busy
);

   localparam int LAT_W = $clog2(ISECT_LAT + 3);
   localparam int OUT_W = (IDX_W + 1 > LAT_W) ? IDX_W + 1 : LAT_W;

   state_t           state, state_next;
   logic [RAY_W-1:0] ray_q;
   logic [ID_W-1:0]  id_q;
   logic [IDX_W-1:0] num_q, issue_idx, ret_idx, best_idx;
   logic [OUT_W-1:0] outstanding;
   logic             anyhit_q, accept, last_issue, hit_acc, upd, qual, stop_issue;
   hit_rec_t         best;

   assign accept     = ray_valid && ray_ready;
   assign last_issue = (issue_idx == num_q - 1'b1);
   // Returns are only meaningful while a ray has pairs in flight.
   assign hit_acc    = hit_valid && (state == S_ISSUE || state == S_DRAIN) && (outstanding != '0);
   assign upd        = hit_acc && !(anyhit_q && best.hit);
   assign stop_issue = anyhit_q && upd && qual;

`ifdef RAYSCHED_ANYHIT_EN
   always_ff @(posedge clk) begin
      if (reset)       anyhit_q <= 1'b0;
      else if (accept) anyhit_q <= ray_anyhit;
   end
`else
   assign anyhit_q = 1'b0;
`endif

   // NOTE: every output of this block gets a default first so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      ray_ready  = 1'b0;
      tri_rd     = 1'b0;
      res_valid  = 1'b0;
      case (state)
         S_IDLE: begin
            ray_ready = 1'b1;
            // An empty scene passes through DRAIN, giving the 2-cycle latency.
            if (ray_valid) state_next = (num_tris == '0) ? S_DRAIN : S_ISSUE;
         end
         S_ISSUE: begin
            tri_rd = 1'b1;
            if (last_issue || stop_issue) state_next = S_DRAIN;
         end
         S_DRAIN: begin
            // Leave on the last return itself so its update is visible in DONE.
            if (outstanding == '0 || (hit_acc && outstanding == OUT_W'(1))) state_next = S_DONE;
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         ray_q       <= '0;
         id_q        <= '0;
         num_q       <= '0;
         issue_idx   <= '0;
         ret_idx     <= '0;
         outstanding <= '0;
         isect_valid <= 1'b0;
      end else begin
         state       <= state_next;
         isect_valid <= tri_rd;
         if (accept) begin
            ray_q     <= ray_in;
            id_q      <= ray_id;
            num_q     <= num_tris;
            issue_idx <= '0;
            ret_idx   <= '0;
         end else begin
            if (tri_rd)  issue_idx <= issue_idx + 1'b1;
            if (hit_acc) ret_idx   <= ret_idx + 1'b1;
         end
         case ({tri_rd, hit_acc})
            2'b10:   outstanding <= outstanding + 1'b1;
            2'b01:   outstanding <= outstanding - 1'b1;
            default: outstanding <= outstanding;
         endcase
      end
   end

   closest_hit_tracker #(.IDX_W(IDX_W)) u_tracker (
      .clk      (clk),
      .reset    (reset),
      .clear    (accept),
      .update   (upd),
      .hit      (hit),
      .hit_t    (hit_t),
      .idx      (ret_idx),
      .qual     (qual),
      .best     (best),
      .best_idx (best_idx)
   );

   assign tri_addr  = issue_idx;
   assign isect_ray = ray_q;
   assign isect_tri = tri_data;
   assign res_hit   = best.hit;
   assign res_t     = best.t;
   assign res_idx   = best_idx;
   assign res_id    = id_q;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ray_scene_scheduler.sv
// Self-checking bench for ray_scene_scheduler with a triangle memory and a
// fixed-latency intersection model. Any-hit cases run when RAYSCHED_ANYHIT_EN is defined.
module tb_ray_scene_scheduler;
   import ray_scene_scheduler_pkg::*;

   localparam int IDX_W     = 10;
   localparam int ID_W      = 8;
   localparam int ISECT_LAT = 6;

   logic             clk = 1'b0;
   logic             reset, ray_valid, ray_ready, tri_rd, isect_valid;
   logic [RAY_W-1:0] ray_in, isect_ray;
   logic [ID_W-1:0]  ray_id, res_id;
   logic [IDX_W-1:0] num_tris, tri_addr, res_idx;
   logic [TRI_W-1:0] tri_data, isect_tri;
   logic             hit_valid, hit, res_valid, res_ready, res_hit, busy;
   logic [31:0]      hit_t, res_t;
`ifdef RAYSCHED_ANYHIT_EN
   logic             ray_anyhit;
`endif

   always #5 clk = ~clk;

   ray_scene_scheduler #(.IDX_W(IDX_W), .ID_W(ID_W), .ISECT_LAT(ISECT_LAT)) dut (
      .clk         (clk),
      .reset       (reset),
      .ray_valid   (ray_valid),
      .ray_ready   (ray_ready),
      .ray_in      (ray_in),
      .ray_id      (ray_id),
      .num_tris    (num_tris),
`ifdef RAYSCHED_ANYHIT_EN
      .ray_anyhit  (ray_anyhit),
`endif
      .tri_rd      (tri_rd),
      .tri_addr    (tri_addr),
      .tri_data    (tri_data),
      .isect_valid (isect_valid),
      .isect_ray   (isect_ray),
      .isect_tri   (isect_tri),
      .hit_valid   (hit_valid),
      .hit         (hit),
      .hit_t       (hit_t),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_hit     (res_hit),
      .res_t       (res_t),
      .res_idx     (res_idx),
      .res_id      (res_id),
      .busy        (busy)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Per-triangle intersection outcome for the current scene.
   logic        tab_hit [1024];
   logic [31:0] tab_t   [1024];

   // Triangle words carry their own index in the low bits so the
   // intersection model can tell which triangle it was handed.
   function automatic logic [TRI_W-1:0] tri_word(input int i);
      logic [TRI_W-1:0] w;
      w = {9{32'(i) * 32'h9E3779B1}};
      w[IDX_W-1:0] = i[IDX_W-1:0];
      return w;
   endfunction

   // Environment: memory answers one cycle after tri_rd; each pair returns
   // exactly ISECT_LAT cycles after isect_valid, in order.
   typedef struct { int due; int idx; } ret_t;
   ret_t             pend[$];
   ret_t             r;
   int               cyc = 0;
   int               rd_count = 0;
   logic             prev_rd = 1'b0;
   logic [IDX_W-1:0] prev_addr = '0;

   always @(posedge clk) begin
      cyc++;
      #1;
      tri_data = prev_rd ? tri_word(int'(prev_addr)) : '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         r         = pend.pop_front();
         hit_valid = 1'b1;
         hit       = tab_hit[r.idx];
         hit_t     = tab_t[r.idx];
      end else begin
         hit_valid = 1'b0;
         hit       = 1'($urandom);
         hit_t     = $urandom;
      end
      #1;
      prev_rd   = tri_rd;
      prev_addr = tri_addr;
      if (tri_rd) rd_count++;
      if (isect_valid) pend.push_back('{due: cyc + ISECT_LAT, idx: int'(isect_tri[IDX_W-1:0])});
   end

   // Reference: closest mode takes the smallest qualifying distance and then
   // the lowest index carrying it; any-hit mode takes the first qualifying one.
   task automatic model(input int n, input bit anyhit,
                        output logic eh, output logic [31:0] et, output int ei);
      eh = 1'b0;
      et = FMAX_T;
      ei = 0;
      if (anyhit) begin
         for (int i = 0; i < n; i++) begin
            if (tab_hit[i] && $signed(tab_t[i]) > FP0P001 && $signed(tab_t[i]) < FMAX_T) begin
               eh = 1'b1; et = tab_t[i]; ei = i;
               break;
            end
         end
      end else begin
         for (int i = 0; i < n; i++)
            if (tab_hit[i] && $signed(tab_t[i]) > FP0P001 && $signed(tab_t[i]) < $signed(et)) begin
               et = tab_t[i]; eh = 1'b1;
            end
         if (eh)
            for (int i = 0; i < n; i++)
               if (tab_hit[i] && tab_t[i] == et) begin
                  ei = i;
                  break;
               end
      end
   endtask

   function automatic logic [31:0] pick_t();
      case ($urandom_range(0, 6))
         0:       return FP0P001;
         1:       return FP0P001 + 1;
         2:       return 32'h08000000;
         3:       return 32'hF0000000;
         4:       return FMAX_T;
         5:       return 32'h00100000 + $urandom_range(0, 3);
         default: return $urandom;
      endcase
   endfunction

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         tab_hit[i] = ($urandom_range(0, 3) != 0);
         tab_t[i]   = pick_t();
      end
   endtask

   task automatic run_ray(input int n, input bit anyhit, input int hold, input string tag);
      logic [RAY_W-1:0]          ray;
      logic [ID_W-1:0]           id;
      logic                      eh;
      logic [31:0]               et;
      int                        ei, lat;
      logic [IDX_W+ID_W+32:0]    snap;
      ray = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      id  = ID_W'($urandom);
      model(n, anyhit, eh, et, ei);
      rd_count = 0;
      check({tag, " ray_ready"}, ray_ready, 1);
      ray_valid = 1'b1;
      ray_in    = ray;
      ray_id    = id;
      num_tris  = IDX_W'(n);
`ifdef RAYSCHED_ANYHIT_EN
      ray_anyhit = anyhit;
`endif
      @(posedge clk); #3;
      ray_valid = 1'b0;
      ray_in    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      ray_id    = ID_W'($urandom);
      num_tris  = IDX_W'($urandom);
      lat = 1;
      while (!res_valid && lat < 3000) begin
         @(posedge clk); #3;
         lat++;
      end
      if (!res_valid) begin
         check({tag, " res_valid timeout"}, res_valid, 1);
         return;
      end
      if (!anyhit) begin
         check({tag, " latency"}, lat, (n == 0) ? 2 : n + ISECT_LAT + 2);
         check({tag, " reads"}, rd_count, n);
      end else begin
         check({tag, " reads bounded"}, rd_count <= ei + ISECT_LAT + 2, 1);
      end
      check({tag, " res_hit"}, res_hit, eh);
      check({tag, " res_t"}, res_t, et);
      check({tag, " res_idx"}, res_idx, ei);
      check({tag, " res_id"}, res_id, id);
      check({tag, " isect_ray"}, isect_ray, ray);
      check({tag, " busy"}, busy, 1);
      snap = {res_hit, res_t, res_idx, res_id};
      repeat (hold) begin
         @(posedge clk); #3;
      end
      if (hold > 0) begin
         check({tag, " held stable"}, {res_hit, res_t, res_idx, res_id}, snap);
         check({tag, " held valid"}, res_valid, 1);
         check({tag, " held ray_ready"}, ray_ready, 0);
      end
      res_ready = 1'b1;
      @(posedge clk); #3;
      res_ready = 1'b0;
      check({tag, " released"}, res_valid, 0);
      check({tag, " next ray_ready"}, ray_ready, 1);
   endtask

   task automatic reset_mid_issue();
      int guard;
      for (int i = 0; i < 8; i++) begin
         tab_hit[i] = 1'b1;
         tab_t[i]   = 32'h00100000 + 32'(i);
      end
      ray_valid = 1'b1;
      ray_in    = {6{$urandom}};
      ray_id    = 8'h5A;
      num_tris  = 8;
      @(posedge clk); #3;
      ray_valid = 1'b0;
      guard = 0;
      while (!(tri_rd && tri_addr == 3) && guard < 20) begin
         @(posedge clk); #3;
         guard++;
      end
      check("t5 reached idx3", tri_rd && tri_addr == 3, 1);
      reset = 1'b1;
      @(posedge clk); #3;
      reset = 1'b0;
      check("t5 tri_rd off", tri_rd, 0);
      check("t5 idle", busy, 0);
      check("t5 ray_ready", ray_ready, 1);
      check("t5 isect_valid off", isect_valid, 0);
      repeat (12) begin
         @(posedge clk); #3;
      end
      check("t5 late hits ignored hit", res_hit, 0);
      check("t5 late hits ignored t", res_t, FMAX_T);
      check("t5 still idle", busy, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset     = 1'b1;
      ray_valid = 1'b0;
      ray_in    = '0;
      ray_id    = '0;
      num_tris  = '0;
      res_ready = 1'b0;
      hit_valid = 1'b0;
      hit       = 1'b0;
      hit_t     = '0;
      tri_data  = '0;
`ifdef RAYSCHED_ANYHIT_EN
      ray_anyhit = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #3;
      check("reset ray_ready", ray_ready, 1);
      check("reset busy", busy, 0);
      check("reset res_valid", res_valid, 0);
      check("reset tri_rd", tri_rd, 0);
      check("reset tri_addr", tri_addr, 0);
      check("reset isect_valid", isect_valid, 0);
      check("reset res_hit", res_hit, 0);
      check("reset res_t", res_t, FMAX_T);
      check("reset res_idx", res_idx, 0);
      check("reset res_id", res_id, 0);
      reset = 1'b0;
      @(posedge clk); #3;

      run_ray(0, 1'b0, 0, "t1");

      tab_hit[0] = 1'b0; tab_t[0] = 32'h30000000;
      tab_hit[1] = 1'b1; tab_t[1] = 32'h20000000;
      tab_hit[2] = 1'b1; tab_t[2] = 32'h08000000;
      tab_hit[3] = 1'b1; tab_t[3] = 32'h08000000;
      run_ray(4, 1'b0, 0, "t2");

      tab_hit[0] = 1'b1; tab_t[0] = 32'h00020C49;
      tab_hit[1] = 1'b1; tab_t[1] = 32'hF0000000;
      tab_hit[2] = 1'b1; tab_t[2] = FP0P001;
      run_ray(3, 1'b0, 0, "t3");

      fill_random(5);
      tab_hit[4] = 1'b1; tab_t[4] = 32'h01000000;
      run_ray(5, 1'b0, 10, "t4");

      reset_mid_issue();
      fill_random(8);
      run_ray(8, 1'b0, 1, "t5 next");

`ifdef RAYSCHED_ANYHIT_EN
      tab_hit[0] = 1'b0; tab_t[0] = 32'h00100000;
      tab_hit[1] = 1'b1; tab_t[1] = 32'h01000000;
      for (int i = 2; i < 16; i++) begin
         tab_hit[i] = 1'b1;
         tab_t[i]   = 32'h00100000;
      end
      run_ray(16, 1'b1, 0, "t6");
`endif

      for (int k = 0; k < 12; k++) begin
         int  n;
         bit  ah;
         n  = $urandom_range(0, 24);
         ah = 1'b0;
`ifdef RAYSCHED_ANYHIT_EN
         ah = 1'($urandom);
`endif
         fill_random(n);
         run_ray(n, ah, $urandom_range(0, 3), $sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
